// File: rtl/eight_bit_instruction_sequencer.sv
// Program sequencer: 16x8 program memory, local HALT/JUMP, other opcodes issued via valid/ready.
// Issue latency 2 cycles after start or acceptance; instruction held stable while instr_ready is low.
module eight_bit_instruction_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       prog_we,
  input  logic [3:0] prog_addr,
  input  logic [7:0] prog_data,
  output logic [7:0] instruction,
  output logic       instr_valid,
  input  logic       instr_ready,
  output logic [3:0] pc,
  output logic       busy,
  output logic       halted,
  output logic [7:0] issued_count
);

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, ISSUE, HALTED} state_t;

  localparam logic [3:0] OP_HALT = 4'hF;
  localparam logic [3:0] OP_JUMP = 4'hE;

  state_t     state;
  logic [7:0] mem [16];
  logic [7:0] ir;
  logic       stopped;

  assign stopped = (state == IDLE) || (state == HALTED);

  // Program memory is deliberately left out of reset; writes only land while stopped.
  always_ff @(posedge clk) begin
    if (prog_we && stopped) mem[prog_addr] <= prog_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      pc           <= 4'd0;
      issued_count <= 8'd0;
      ir           <= 8'h00;
    end else if (abort) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE, HALTED: begin
          if (start) begin
            pc           <= 4'd0;
            issued_count <= 8'd0;
            state        <= FETCH;
          end
        end
        FETCH: begin
          ir    <= mem[pc];
          state <= DECODE;
        end
        DECODE: begin
          if (ir[7:4] == OP_HALT) begin
            state <= HALTED;
          end else if (ir[7:4] == OP_JUMP) begin
            pc    <= ir[3:0];
            state <= FETCH;
          end else begin
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (instr_ready) begin
            pc    <= 4'(pc + 4'd1);
            if (issued_count != 8'hFF) issued_count <= 8'(issued_count + 8'd1);
            state <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Flags decode straight from the state register so reset clears them without a clock.
  assign instruction = ir;
  assign instr_valid = (state == ISSUE);
  assign busy        = (state == FETCH) || (state == DECODE) || (state == ISSUE);
  assign halted      = (state == HALTED);

endmodule

// File: tb/tb_eight_bit_instruction_sequencer.sv
// Bench for eight_bit_instruction_sequencer: directed scenarios plus randomized runs,
// all cycles checked against a countdown-based behavioural model.
module tb_eight_bit_instruction_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0, abort = 1'b0, prog_we = 1'b0, instr_ready = 1'b0;
  logic [3:0] prog_addr = 4'd0;
  logic [7:0] prog_data = 8'd0;
  logic [7:0] instruction, issued_count;
  logic       instr_valid, busy, halted;
  logic [3:0] pc;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  eight_bit_instruction_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .instruction(instruction), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .pc(pc), .busy(busy), .halted(halted), .issued_count(issued_count)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Model: mode 0 stopped, 1 running, 2 halted; m_d counts edges left before the entry at m_pc resolves.
  logic [7:0] m_mem [16];
  int         m_mode = 0;
  int         m_d = 0;
  logic [3:0] m_pc = 4'd0;
  int         m_cnt = 0;
  logic [7:0] m_ins = 8'h00;

  always @(posedge clk or negedge rst_n) begin
    logic [7:0] e;
    if (!rst_n) begin
      m_mode = 0; m_pc = 4'd0; m_cnt = 0; m_ins = 8'h00; m_d = 0;
    end else begin
      if (prog_we && m_mode != 1) m_mem[prog_addr] = prog_data;
      if (abort) begin
        m_mode = 0;
      end else if (m_mode != 1) begin
        if (start) begin m_mode = 1; m_pc = 4'd0; m_cnt = 0; m_d = 2; end
      end else if (m_d == 0) begin
        if (instr_ready) begin
          m_pc = m_pc + 4'd1;
          if (m_cnt < 255) m_cnt = m_cnt + 1;
          m_d = 2;
        end
      end else begin
        m_d = m_d - 1;
        if (m_d == 0) begin
          e = m_mem[m_pc];
          if (e[7:4] == 4'hF) m_mode = 2;
          else if (e[7:4] == 4'hE) begin m_pc = e[3:0]; m_d = 2; end
          else m_ins = e;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Per-cycle comparison and accept logging, on the falling edge.
  logic [7:0] acc_ins[$];
  int         acc_cyc[$];
  always @(negedge clk) begin
    logic mv;
    mv = (m_mode == 1) && (m_d == 0);
    chk("instr_valid", instr_valid, mv);
    chk("busy", busy, m_mode == 1);
    chk("halted", halted, m_mode == 2);
    chk("pc", pc, m_pc);
    chk("issued_count", issued_count, m_cnt);
    if (mv) chk("instruction", instruction, m_ins);
    if (rst_n && instr_valid && instr_ready && !abort) begin
      acc_ins.push_back(instruction);
      acc_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic load(input logic [3:0] a, input logic [7:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!instr_valid && n < 20) begin tick(); n++; end
    chk("wait_valid", instr_valid, 1);
  endtask

  task automatic wait_halt(input int lim);
    int n = 0;
    while (!halted && n < lim) begin tick(); n++; end
    chk("wait_halt", halted, 1);
  endtask

  task automatic stop();
    abort = 1'b1; tick(); abort = 1'b0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    chk("rst_instruction", instruction, 8'h00);
    chk("rst_valid", instr_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_pc", pc, 0);
    chk("rst_count", issued_count, 0);

    for (int i = 0; i < 16; i++) load(4'(i), 8'hF0);

    // Asynchronous reset while an instruction is waiting.
    load(4'd0, 8'h12);
    pulse_start();
    wait_valid();
    chk("issue_12", instruction, 8'h12);
    #2 rst_n = 1'b0;
    #1 chk("async_valid_drop", instr_valid, 0);
    chk("async_busy", busy, 0);
    chk("async_instruction", instruction, 8'h00);
    @(posedge clk); #1 rst_n = 1'b1;

    // Straight-line program, with a write attempted while busy.
    load(4'd0, 8'h04); load(4'd1, 8'h18); load(4'd2, 8'h9C); load(4'd3, 8'hF0);
    instr_ready = 1'b1;
    acc_ins.delete(); acc_cyc.delete();
    pulse_start();
    load(4'd1, 8'h77);
    wait_halt(60);
    chk("sl_n", acc_ins.size(), 3);
    if (acc_ins.size() == 3) begin
      chk("sl_0", acc_ins[0], 8'h04);
      chk("sl_1_protected", acc_ins[1], 8'h18);
      chk("sl_2", acc_ins[2], 8'h9C);
      chk("sl_gap01", acc_cyc[1] - acc_cyc[0], 3);
      chk("sl_gap12", acc_cyc[2] - acc_cyc[1], 3);
    end
    chk("sl_pc", pc, 3);
    chk("sl_count", issued_count, 3);

    // Backpressure for 5 cycles on the first instruction.
    instr_ready = 1'b0;
    acc_ins.delete(); acc_cyc.delete();
    pulse_start();
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold", instruction, 8'h04);
      tick();
    end
    instr_ready = 1'b1;
    wait_halt(60);
    chk("bp_n", acc_ins.size(), 3);
    if (acc_ins.size() == 3) begin
      chk("bp_0", acc_ins[0], 8'h04);
      chk("bp_1", acc_ins[1], 8'h18);
      chk("bp_2", acc_ins[2], 8'h9C);
    end

    // Jump to 15, issue, wrap to 0.
    load(4'd0, 8'hEF); load(4'd15, 8'h21);
    acc_ins.delete(); acc_cyc.delete();
    pulse_start();
    begin
      int n = 0;
      while (acc_ins.size() == 0 && n < 30) begin tick(); n++; end
    end
    chk("jw_issue", acc_ins.size() > 0 ? acc_ins[0] : 8'h00, 8'h21);
    chk("jw_wrap_pc", pc, 0);
    stop();
    chk("jw_count", issued_count, 1);
    load(4'd0, 8'hE5); load(4'd5, 8'hF0);
    pulse_start();
    wait_halt(30);
    chk("jw_halt_pc", pc, 5);
    chk("jw_halt_count", issued_count, 0);

    // Abort on the same edge as acceptance.
    load(4'd0, 8'h04);
    instr_ready = 1'b0;
    pulse_start();
    wait_valid();
    abort = 1'b1; instr_ready = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_valid", instr_valid, 0);
    chk("ab_busy", busy, 0);
    chk("ab_count", issued_count, 0);
    chk("ab_pc", pc, 0);

    // Saturation of the issued counter.
    load(4'd0, 8'h01); load(4'd1, 8'hE0);
    acc_ins.delete(); acc_cyc.delete();
    pulse_start();
    begin
      int n = 0;
      while (acc_ins.size() < 300 && n < 1500) begin tick(); n++; end
    end
    chk("sat_accepts", acc_ins.size() >= 300, 1);
    chk("sat_count", issued_count, 255);
    stop();

    // Randomized programs and traffic.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 16; i++) begin
        int k;
        k = $urandom_range(0, 9);
        if (k < 2) load(4'(i), {4'hF, 4'($urandom)});
        else if (k < 4) load(4'(i), {4'hE, 4'($urandom)});
        else load(4'(i), {4'($urandom_range(0, 13)), 4'($urandom)});
      end
      for (int c = 0; c < 400; c++) begin
        instr_ready = ($urandom_range(0, 2) != 0);
        start       = ($urandom_range(0, 9) == 0);
        abort       = ($urandom_range(0, 49) == 0);
        prog_we     = ($urandom_range(0, 7) == 0);
        prog_addr   = 4'($urandom);
        prog_data   = 8'($urandom);
        tick();
      end
      start = 1'b0; prog_we = 1'b0;
      stop();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
